posit_decode_pipe: RTL and testbench

//  Parametrised, pipelined posit field extractor. Successor to the 8-bit combinational regime shifter.

---
 rtl/posit_pkg.sv | 31 +++
 rtl/posit_regime_count.sv | 32 +++
 rtl/posit_decode_pipe.sv | 154 +++++++++++++++
 tb/tb_posit_decode_pipe.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/posit_pkg.sv
// Shared sizing helpers and small types for the posit decode/encode blocks.
package posit_pkg;

  typedef struct packed {
    logic sign;
    logic zero;
    logic nar;
  } posit_flags_t;

  function automatic int posit_bias(input int n, input int es);
    return (n - 2) << es;
  endfunction

  function automatic int posit_ew(input int n, input int es);
    return $clog2(((2 * (n - 2)) + 1) << es);
  endfunction

  function automatic int posit_fw(input int n, input int es);
    return n - 3 - es;
  endfunction

  // Patterns are returned 32 bits wide; callers size-cast to their N.
  function automatic logic [31:0] posit_nar_pat(input int n);
    return 32'd1 << (n - 1);
  endfunction

  function automatic logic [31:0] posit_zero_pat(input int n);
    return (n > 0) ? 32'd0 : 32'd0;
  endfunction

endpackage

// File: rtl/posit_regime_count.sv
// Leading-run detector over the N-1 magnitude bits below the sign: run polarity,
// saturating run length and a one-hot select of how far past regime+terminator to shift.
module posit_regime_count #(
  parameter int N = 8
) (
  input  logic [N-2:0]         bits_i,
  output logic                 r_o,
  output logic [$clog2(N)-1:0] m_o,
  output logic [N-3:0]         sel_o
);
  localparam int MW = $clog2(N);

  assign r_o = bits_i[N-2];

  // Ascending scan: the last hit is the highest differing bit, i.e. the terminator.
  always_comb begin
    m_o = MW'(N - 1);
    for (int i = 0; i <= N - 3; i++) begin
      if (bits_i[i] != r_o) m_o = MW'(N - 2 - i);
    end
  end

  // sel_o[j] means "drop j+2 leading bits"; runs of N-2 and N-1 both consume everything.
  for (genvar gi = 0; gi <= N - 3; gi++) begin : g_sel
    if (gi == N - 3) begin : g_last
      assign sel_o[gi] = (m_o == MW'(N - 2)) || (m_o == MW'(N - 1));
    end else begin : g_mid
      assign sel_o[gi] = (m_o == MW'(gi + 1));
    end
  end

endmodule

// File: rtl/posit_decode_pipe.sv
// Two-stage valid/ready posit field extractor: S1 negates to magnitude and flags
// specials, S2 decodes regime/exponent/fraction into a biased exponent.
module posit_decode_pipe
  import posit_pkg::*;
#(
  parameter int N  = 8,
  parameter int ES = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N-1:0]               posit_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_sign,
  output logic [posit_ew(N,ES)-1:0]  out_exp,
  output logic [posit_fw(N,ES)-1:0]  out_frac,
  output logic                       out_zero,
  output logic                       out_nar
);
  localparam int BIAS = posit_bias(N, ES);
  localparam int EW   = posit_ew(N, ES);
  localparam int FW   = posit_fw(N, ES);
  localparam int MW   = $clog2(N);
  localparam logic [N-1:0]      NAR_PAT  = N'(posit_nar_pat(N));
  localparam logic [N-1:0]      ZERO_PAT = N'(posit_zero_pat(N));
  localparam logic signed [EW:0] BIAS_S  = (EW + 1)'(BIAS);
  localparam logic signed [EW:0] ONE_S   = (EW + 1)'(1);

  logic          s1_valid_q, s1_valid_d;
  logic [N-2:0]  s1_mag_q, s1_mag_d;
  posit_flags_t  s1_flags_q, s1_flags_d;
  logic          s2_valid_q, s2_valid_d;
  logic          s2_sign_q, s2_sign_d, s2_zero_q, s2_zero_d, s2_nar_q, s2_nar_d;
  logic [EW-1:0] s2_exp_q, s2_exp_d;
  logic [FW-1:0] s2_frac_q, s2_frac_d;

  logic s2_adv, s1_adv;
  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  logic          r;
  logic [MW-1:0] m;
  logic [N-3:0]  sel;

  posit_regime_count #(.N(N)) u_regime (
    .bits_i (s1_mag_q),
    .r_o    (r),
    .m_o    (m),
    .sel_o  (sel)
  );

  // Bits below the two always-consumed leading bits, left-shifted by the one-hot amount.
  logic [N-4:0] shift_terms [N-3:0];
  logic [N-4:0] rem;
  for (genvar gi = 0; gi <= N - 3; gi++) begin : g_shift
    assign shift_terms[gi] = sel[gi] ? (s1_mag_q[N-4:0] << gi) : '0;
  end

  always_comb begin
    rem = '0;
    for (int i = 0; i <= N - 3; i++) rem = rem | shift_terms[i];
  end

  logic signed [EW:0] m_s, k_s, e_s, exp_s;
  if (ES > 0) begin : g_exp
    assign e_s = signed'((EW + 1)'(rem[N-4 -: ES]));
  end else begin : g_noexp
    assign e_s = '0;
  end

  assign m_s   = signed'((EW + 1)'(m));
  assign k_s   = r ? (m_s - ONE_S) : -m_s;
  assign exp_s = (k_s <<< ES) + e_s + BIAS_S;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_mag_d   = s1_mag_q;
    s1_flags_d = s1_flags_q;
    if (flush) begin
      s1_valid_d = 1'b0;
    end else if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        // Only the low N-1 bits of the negation feed the regime and fraction.
        s1_mag_d        = posit_in[N-1] ? -posit_in[N-2:0] : posit_in[N-2:0];
        s1_flags_d.sign = posit_in[N-1];
        s1_flags_d.zero = (posit_in == ZERO_PAT);
        s1_flags_d.nar  = (posit_in == NAR_PAT);
      end
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_sign_d  = s2_sign_q;
    s2_zero_d  = s2_zero_q;
    s2_nar_d   = s2_nar_q;
    s2_exp_d   = s2_exp_q;
    s2_frac_d  = s2_frac_q;
    if (flush) begin
      s2_valid_d = 1'b0;
    end else if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_sign_d = s1_flags_q.sign;
        s2_zero_d = s1_flags_q.zero;
        s2_nar_d  = s1_flags_q.nar;
        if (s1_flags_q.zero || s1_flags_q.nar) begin
          s2_exp_d  = '0;
          s2_frac_d = '0;
        end else begin
          s2_exp_d  = exp_s[EW] ? '0 : exp_s[EW-1:0];
          s2_frac_d = rem[FW-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_mag_q   <= '0;
      s1_flags_q <= '0;
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_zero_q  <= 1'b0;
      s2_nar_q   <= 1'b0;
      s2_exp_q   <= '0;
      s2_frac_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_mag_q   <= s1_mag_d;
      s1_flags_q <= s1_flags_d;
      s2_valid_q <= s2_valid_d;
      s2_sign_q  <= s2_sign_d;
      s2_zero_q  <= s2_zero_d;
      s2_nar_q   <= s2_nar_d;
      s2_exp_q   <= s2_exp_d;
      s2_frac_q  <= s2_frac_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_sign  = s2_sign_q;
  assign out_zero  = s2_zero_q;
  assign out_nar   = s2_nar_q;
  assign out_exp   = s2_exp_q;
  assign out_frac  = s2_frac_q;

endmodule

// File: tb/tb_posit_decode_pipe.sv
// Directed bench for posit_decode_pipe at N=8/ES=0 and N=16/ES=1 with a
// value-level posit decoding model and per-transfer scoreboard.
module tb_posit_decode_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic flush8, in_valid8, in_ready8, out_valid8, out_ready8, out_sign8, out_zero8, out_nar8;
  logic [7:0] posit8;
  logic [3:0] exp8;
  logic [4:0] frac8;
  logic flush16, in_valid16, in_ready16, out_valid16, out_ready16, out_sign16, out_zero16, out_nar16;
  logic [15:0] posit16;
  logic [5:0]  exp16;
  logic [11:0] frac16;

  posit_decode_pipe #(.N(8), .ES(0)) dut8 (
    .clk(clk), .rst_n(rst_n), .flush(flush8), .in_valid(in_valid8), .in_ready(in_ready8),
    .posit_in(posit8), .out_valid(out_valid8), .out_ready(out_ready8), .out_sign(out_sign8),
    .out_exp(exp8), .out_frac(frac8), .out_zero(out_zero8), .out_nar(out_nar8)
  );

  posit_decode_pipe #(.N(16), .ES(1)) dut16 (
    .clk(clk), .rst_n(rst_n), .flush(flush16), .in_valid(in_valid16), .in_ready(in_ready16),
    .posit_in(posit16), .out_valid(out_valid16), .out_ready(out_ready16), .out_sign(out_sign16),
    .out_exp(exp16), .out_frac(frac16), .out_zero(out_zero16), .out_nar(out_nar16)
  );

  typedef struct {
    longint posit;
    int sign, exp, frac, zero, nar, cyc, lat;
  } item_t;

  item_t q8[$];
  item_t q16[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat_mode = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic int bitof(input longint unsigned v, input int i);
    return (i >= 0) ? int'((v >> i) & 64'd1) : 0;
  endfunction

  // Posit decoding from the number-format definition: walk the regime run,
  // read ES exponent bits then the fraction, padding missing bits with zero.
  function automatic item_t model(input int n, input int es, input longint unsigned p);
    item_t it;
    longint unsigned mask, mag;
    int r, m, i, pos, e, f;
    it = '{default: 0};
    it.posit = longint'(p);
    mask = (64'd1 << n) - 64'd1;
    it.sign = bitof(p, n - 1);
    if (p == 0) begin it.zero = 1; return it; end
    if (p == (64'd1 << (n - 1))) begin it.nar = 1; return it; end
    mag = (it.sign != 0) ? ((~p + 64'd1) & mask) : p;
    r = bitof(mag, n - 2);
    m = 0;
    i = n - 2;
    while (i >= 0 && bitof(mag, i) == r) begin m++; i--; end
    pos = i - 1;
    e = 0;
    for (int j = 0; j < es; j++) begin e = e * 2 + bitof(mag, pos); pos--; end
    f = 0;
    for (int j = 0; j < n - 3 - es; j++) begin f = f * 2 + bitof(mag, pos); pos--; end
    it.exp = ((r != 0) ? m - 1 : -m) * (1 << es) + e + (n - 2) * (1 << es);
    it.frac = f;
    return it;
  endfunction

  task automatic pin(input int n, input int es, input longint unsigned p,
                     input int sign, input int exp, input int frac, input int zero, input int nar);
    item_t it;
    it = model(n, es, p);
    check($sformatf("pin_sign_%0h", p), it.sign, sign);
    check($sformatf("pin_exp_%0h", p), it.exp, exp);
    check($sformatf("pin_frac_%0h", p), it.frac, frac);
    check($sformatf("pin_flags_%0h", p), it.zero * 2 + it.nar, zero * 2 + nar);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : mon8
    item_t e;
    if (!rst_n) begin
      q8.delete();
    end else begin
      if (out_valid8 && out_ready8) begin
        if (q8.size() == 0) begin
          check("unexpected_out8", 1, 0);
        end else begin
          e = q8.pop_front();
          $display("n8  in=%02h sign=%0d exp=%0d frac=%0d zero=%0d nar=%0d", e.posit,
                   out_sign8, exp8, frac8, out_zero8, out_nar8);
          check("sign8", out_sign8, e.sign);
          check("exp8", exp8, e.exp);
          check("frac8", frac8, e.frac);
          check("zero8", out_zero8, e.zero);
          check("nar8", out_nar8, e.nar);
          if (e.lat != 0) check("latency8", cyc - e.cyc, 2);
        end
      end
      if (flush8) q8.delete();
      else if (in_valid8 && in_ready8) begin
        e = model(8, 0, 64'(posit8));
        e.cyc = cyc;
        e.lat = lat_mode;
        q8.push_back(e);
      end
    end
  end

  always @(negedge clk) begin : mon16
    item_t e;
    if (!rst_n) begin
      q16.delete();
    end else begin
      if (out_valid16 && out_ready16) begin
        if (q16.size() == 0) begin
          check("unexpected_out16", 1, 0);
        end else begin
          e = q16.pop_front();
          $display("n16 in=%04h sign=%0d exp=%0d frac=%0h zero=%0d nar=%0d", e.posit,
                   out_sign16, exp16, frac16, out_zero16, out_nar16);
          check("sign16", out_sign16, e.sign);
          check("exp16", exp16, e.exp);
          check("frac16", frac16, e.frac);
          check("zero16", out_zero16, e.zero);
          check("nar16", out_nar16, e.nar);
        end
      end
      if (flush16) q16.delete();
      else if (in_valid16 && in_ready16) q16.push_back(model(16, 1, 64'(posit16)));
    end
  end

  task automatic push8(input logic [7:0] p);
    int n;
    n = 0;
    posit8 = p;
    in_valid8 = 1'b1;
    @(negedge clk);
    while (!in_ready8 && n < 50) begin n++; @(negedge clk); end
    if (n >= 50) check("push8_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
  endtask

  task automatic push16(input logic [15:0] p);
    int n;
    n = 0;
    posit16 = p;
    in_valid16 = 1'b1;
    @(negedge clk);
    while (!in_ready16 && n < 50) begin n++; @(negedge clk); end
    if (n >= 50) check("push16_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid16 = 1'b0;
  endtask

  task automatic drain8();
    int n;
    n = 0;
    while ((q8.size() != 0 || out_valid8) && n < 100) begin n++; @(negedge clk); end
    if (n >= 100) check("drain8_timeout", 0, 1);
  endtask

  task automatic drain16();
    int n;
    n = 0;
    while ((q16.size() != 0 || out_valid16) && n < 100) begin n++; @(negedge clk); end
    if (n >= 100) check("drain16_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    flush8 = 1'b0; in_valid8 = 1'b0; out_ready8 = 1'b1; posit8 = '0;
    flush16 = 1'b0; in_valid16 = 1'b0; out_ready16 = 1'b1; posit16 = '0;

    pin(8, 0, 'h40, 0, 6, 0, 0, 0);
    pin(8, 0, 'h60, 0, 7, 0, 0, 0);
    pin(8, 0, 'h7F, 0, 12, 0, 0, 0);
    pin(8, 0, 'h01, 0, 0, 0, 0, 0);
    pin(8, 0, 'h00, 0, 0, 0, 1, 0);
    pin(8, 0, 'h80, 1, 0, 0, 0, 1);
    pin(8, 0, 'hC0, 1, 6, 0, 0, 0);
    pin(8, 0, 'h50, 0, 6, 16, 0, 0);
    pin(8, 0, 'h13, 0, 4, 6, 0, 0);
    pin(16, 1, 'h4000, 0, 28, 0, 0, 0);
    pin(16, 1, 'h7FFF, 0, 56, 0, 0, 0);
    pin(16, 1, 'h0001, 0, 0, 0, 0, 0);
    pin(16, 1, 'h5A3C, 0, 29, 'hA3C, 0, 0);

    repeat (3) @(negedge clk);
    check("rst_out_valid8", out_valid8, 0);
    check("rst_out_valid16", out_valid16, 0);
    check("rst_exp8", exp8, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready8", in_ready8, 1);
    check("post_rst_in_ready16", in_ready16, 1);
    @(posedge clk); #1;

    // Streaming with end-to-end latency tracking
    lat_mode = 1;
    push8(8'h40); push8(8'h60); push8(8'h7F); push8(8'h01);
    drain8();
    lat_mode = 0;

    // Specials, negatives, fractions
    push8(8'h00); push8(8'h80); push8(8'hC0); push8(8'h50); push8(8'h13); push8(8'hED);
    drain8();

    push16(16'h4000); push16(16'h7FFF); push16(16'h0001); push16(16'h5A3C);
    push16(16'hFFFF); push16(16'h8000); push16(16'hB3C1);
    drain16();

    // Backpressure: consumer stalls four cycles while six items are offered
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    fork
      begin
        push8(8'h40); push8(8'h48); push8(8'h13); push8(8'hC0); push8(8'h7F); push8(8'h22);
      end
      begin
        repeat (4) @(negedge clk);
        check("bp_in_ready_low", in_ready8, 0);
        check("bp_out_valid_held", out_valid8, 1);
        @(posedge clk); #1;
        out_ready8 = 1'b1;
      end
    join
    drain8();

    // Flush with two items in flight; the concurrently offered item is dropped
    @(posedge clk); #1;
    push8(8'h60); push8(8'h13);
    flush8 = 1'b1; in_valid8 = 1'b1; posit8 = 8'h7F;
    @(posedge clk); #1;
    flush8 = 1'b0; in_valid8 = 1'b0;
    @(negedge clk);
    check("flush_out_valid", out_valid8, 0);
    check("flush_in_ready", in_ready8, 1);
    @(posedge clk); #1;
    push8(8'h50);
    drain8();

    // Asynchronous reset mid-stream
    push8(8'h40); push8(8'h13);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", out_valid8, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_no_partial", out_valid8, 0);
    @(posedge clk); #1;
    push8(8'h9C);
    drain8();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
